// File: rtl/multicycle_control.sv
// Moore control FSM for a small multicycle datapath: fetch, decode, execute,
// optional mult/div or memory wait with timeout, and register writeback.
module multicycle_control #(
    parameter int OP_W    = 5,
    parameter int FUNC_W  = 5,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [OP_W-1:0]   opcode,
    input  logic [FUNC_W-1:0] func,
    input  logic              md_ready,
    input  logic              dmem_ready,
    output logic              pc_we,
    output logic              ir_we,
    output logic              Rwe,
    output logic              Rdst,
    output logic              ALUinB,
    output logic              DMwe,
    output logic              Rwd,
    output logic [FUNC_W-1:0] ALUop,
    output logic              dmem_req,
    output logic              md_start,
    output logic              md_op,
    output logic              busy,
    output logic              illegal,
    output logic              timeout_err
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MDWAIT,
        MEM,
        WB,
        HALT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [OP_W-1:0]   op_latched;
    logic [FUNC_W-1:0] func_latched;
    logic [CNT_W-1:0]  wait_cnt;

    // Instruction classification; fields are compared zero-extended.
    function automatic logic is_rtype(input logic [OP_W-1:0] op, input logic [FUNC_W-1:0] fn);
        return (32'(op) == 32'd0) && (32'(fn) <= 32'd7);
    endfunction

    function automatic logic is_muldiv(input logic [OP_W-1:0] op, input logic [FUNC_W-1:0] fn);
        return is_rtype(op, fn) && (32'(fn) >= 32'd6);
    endfunction

    function automatic logic is_addi(input logic [OP_W-1:0] op);
        return 32'(op) == 32'd5;
    endfunction

    function automatic logic is_sw(input logic [OP_W-1:0] op);
        return 32'(op) == 32'd7;
    endfunction

    function automatic logic is_lw(input logic [OP_W-1:0] op);
        return 32'(op) == 32'd8;
    endfunction

    function automatic logic is_imm(input logic [OP_W-1:0] op);
        return is_addi(op) || is_sw(op) || is_lw(op);
    endfunction

    function automatic logic is_legal(input logic [OP_W-1:0] op, input logic [FUNC_W-1:0] fn);
        return is_rtype(op, fn) || is_imm(op);
    endfunction

    logic live_legal;
    logic dec_rtype;
    logic dec_md;
    logic dec_lw;
    logic dec_sw;
    logic dec_imm;
    logic dec_legal;
    logic wait_ready;
    logic wait_expired;

    assign live_legal   = is_legal(opcode, func);
    assign dec_rtype    = is_rtype(op_latched, func_latched);
    assign dec_md       = is_muldiv(op_latched, func_latched);
    assign dec_lw       = is_lw(op_latched);
    assign dec_sw       = is_sw(op_latched);
    assign dec_imm      = is_imm(op_latched);
    assign dec_legal    = is_legal(op_latched, func_latched);
    assign wait_ready   = (state == MDWAIT) ? md_ready : dmem_ready;
    assign wait_expired = (wait_cnt == WAIT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Instruction fields are captured as DECODE exits, so EXEC onward is
    // immune to the instruction register changing underneath.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_latched   <= '0;
            func_latched <= '0;
        end else if (state == DECODE) begin
            op_latched   <= opcode;
            func_latched <= func;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if ((state == MDWAIT) || (state == MEM)) begin
            if (!wait_ready) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = FETCH;
            FETCH:   state_next = DECODE;
            DECODE:  state_next = live_legal ? EXEC : FETCH;
            EXEC: begin
                if (dec_md) begin
                    state_next = MDWAIT;
                end else if (dec_lw || dec_sw) begin
                    state_next = MEM;
                end else begin
                    state_next = WB;
                end
            end
            MDWAIT: begin
                if (md_ready) begin
                    state_next = WB;
                end else if (wait_expired) begin
                    state_next = HALT;
                end
            end
            MEM: begin
                if (dmem_ready) begin
                    state_next = dec_lw ? WB : FETCH;
                end else if (wait_expired) begin
                    state_next = HALT;
                end
            end
            WB:      state_next = FETCH;
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pc_we       = 1'b0;
        ir_we       = 1'b0;
        Rwe         = 1'b0;
        Rdst        = 1'b0;
        ALUinB      = 1'b0;
        DMwe        = 1'b0;
        Rwd         = 1'b0;
        ALUop       = '0;
        dmem_req    = 1'b0;
        md_start    = 1'b0;
        md_op       = 1'b0;
        busy        = 1'b0;
        illegal     = 1'b0;
        timeout_err = 1'b0;
        case (state)
            FETCH: begin
                pc_we   = 1'b1;
                ir_we   = 1'b1;
                busy    = 1'b1;
                // Latched fields still hold the previous instruction here.
                illegal = !dec_legal;
            end
            DECODE: begin
                busy = 1'b1;
            end
            EXEC: begin
                busy     = 1'b1;
                ALUinB   = dec_imm;
                ALUop    = dec_imm ? '0 : func_latched;
                md_start = dec_md;
                md_op    = dec_md & func_latched[0];
            end
            MDWAIT: begin
                busy  = 1'b1;
                md_op = func_latched[0];
            end
            MEM: begin
                busy     = 1'b1;
                dmem_req = 1'b1;
                DMwe     = dec_sw;
            end
            WB: begin
                busy   = 1'b1;
                Rwe    = 1'b1;
                Rdst   = dec_rtype;
                Rwd    = dec_lw;
                ALUinB = dec_imm;
                ALUop  = dec_imm ? '0 : func_latched;
            end
            HALT: begin
                timeout_err = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: a per-instruction cycle trace is
// built from the decode/latency rules and compared against the DUT each cycle.
`timescale 1ns/1ps
module tb_multicycle_control;

    localparam int OP_W   = 5;
    localparam int FUNC_W = 5;
    localparam int TO     = 15;
    localparam int OUT_W  = 13 + FUNC_W;

    localparam logic [OUT_W-1:0] M_PC   = OUT_W'(1) << (FUNC_W + 12);
    localparam logic [OUT_W-1:0] M_IR   = OUT_W'(1) << (FUNC_W + 11);
    localparam logic [OUT_W-1:0] M_RWE  = OUT_W'(1) << (FUNC_W + 10);
    localparam logic [OUT_W-1:0] M_RDST = OUT_W'(1) << (FUNC_W + 9);
    localparam logic [OUT_W-1:0] M_ALUB = OUT_W'(1) << (FUNC_W + 8);
    localparam logic [OUT_W-1:0] M_DMWE = OUT_W'(1) << (FUNC_W + 7);
    localparam logic [OUT_W-1:0] M_RWD  = OUT_W'(1) << (FUNC_W + 6);
    localparam logic [OUT_W-1:0] M_DREQ = OUT_W'(1) << (FUNC_W + 5);
    localparam logic [OUT_W-1:0] M_MDS  = OUT_W'(1) << (FUNC_W + 4);
    localparam logic [OUT_W-1:0] M_MDOP = OUT_W'(1) << (FUNC_W + 3);
    localparam logic [OUT_W-1:0] M_BUSY = OUT_W'(1) << (FUNC_W + 2);
    localparam logic [OUT_W-1:0] M_ILL  = OUT_W'(1) << (FUNC_W + 1);
    localparam logic [OUT_W-1:0] M_TERR = OUT_W'(1) << FUNC_W;

    logic              clock;
    logic              reset;
    logic [OP_W-1:0]   opcode;
    logic [FUNC_W-1:0] func;
    logic              md_ready;
    logic              dmem_ready;
    logic              pc_we;
    logic              ir_we;
    logic              Rwe;
    logic              Rdst;
    logic              ALUinB;
    logic              DMwe;
    logic              Rwd;
    logic [FUNC_W-1:0] ALUop;
    logic              dmem_req;
    logic              md_start;
    logic              md_op;
    logic              busy;
    logic              illegal;
    logic              timeout_err;
    logic [OUT_W-1:0]  obs;

    multicycle_control #(
        .OP_W    (OP_W),
        .FUNC_W  (FUNC_W),
        .TIMEOUT (TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .opcode      (opcode),
        .func        (func),
        .md_ready    (md_ready),
        .dmem_ready  (dmem_ready),
        .pc_we       (pc_we),
        .ir_we       (ir_we),
        .Rwe         (Rwe),
        .Rdst        (Rdst),
        .ALUinB      (ALUinB),
        .DMwe        (DMwe),
        .Rwd         (Rwd),
        .ALUop       (ALUop),
        .dmem_req    (dmem_req),
        .md_start    (md_start),
        .md_op       (md_op),
        .busy        (busy),
        .illegal     (illegal),
        .timeout_err (timeout_err)
    );

    assign obs = {pc_we, ir_we, Rwe, Rdst, ALUinB, DMwe, Rwd, dmem_req,
                  md_start, md_op, busy, illegal, timeout_err, ALUop};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [OUT_W-1:0]  exp;
        logic              mdr;
        logic              dmr;
        logic [OP_W-1:0]   op;
        logic [FUNC_W-1:0] fn;
        string             tag;
    } cyc_t;

    cyc_t sched[$];
    logic prev_ill;
    int   n_tests;
    int   n_fail;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input string tag, input logic [OUT_W-1:0] exp, input logic mdr,
                        input logic dmr, input logic [OP_W-1:0] op, input logic [FUNC_W-1:0] fn);
        cyc_t c;
        c.exp = exp;
        c.mdr = mdr;
        c.dmr = dmr;
        c.op  = op;
        c.fn  = fn;
        c.tag = tag;
        sched.push_back(c);
    endtask

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    // Expected trace of one instruction. wt = cycles the awaited ready stays
    // low; wt >= TO means it never arrives in time and the controller halts.
    task automatic gen_instr(input string name, input logic [OP_W-1:0] op,
                             input logic [FUNC_W-1:0] fn, input int wt, output bit halted);
        bit r, md, lw, sw, imm, legal;
        logic [OUT_W-1:0] aluf;
        logic [OUT_W-1:0] e;
        int lows;
        r     = (int'(op) == 0) && (int'(fn) <= 7);
        md    = r && (int'(fn) >= 6);
        lw    = int'(op) == 8;
        sw    = int'(op) == 7;
        imm   = lw || sw || (int'(op) == 5);
        legal = r || imm;
        halted = 0;
        push({name, ".FETCH"}, M_PC | M_IR | M_BUSY | (prev_ill ? M_ILL : '0), rbit(), rbit(), op, fn);
        push({name, ".DECODE"}, M_BUSY, rbit(), rbit(), op, fn);
        prev_ill = !legal;
        if (!legal) return;
        aluf = imm ? '0 : OUT_W'(fn);
        e = M_BUSY | aluf | (imm ? M_ALUB : '0) | (md ? (M_MDS | (fn[0] ? M_MDOP : '0)) : '0);
        push({name, ".EXEC"}, e, 1'b1, 1'b1, OP_W'($urandom), FUNC_W'($urandom));
        if (md || lw || sw) begin
            e = md ? (M_BUSY | (fn[0] ? M_MDOP : '0)) : (M_BUSY | M_DREQ | (sw ? M_DMWE : '0));
            lows = (wt < TO) ? wt : TO;
            for (int k = 0; k < lows; k++) begin
                push({name, md ? ".MDWAIT" : ".MEM"}, e, md ? 1'b0 : rbit(), md ? rbit() : 1'b0,
                     OP_W'($urandom), FUNC_W'($urandom));
            end
            if (wt >= TO) begin
                for (int k = 0; k < 3; k++) begin
                    push({name, ".HALT"}, M_TERR, rbit(), rbit(), OP_W'($urandom), FUNC_W'($urandom));
                end
                halted = 1;
                return;
            end
            push({name, md ? ".MDWAIT_rdy" : ".MEM_rdy"}, e, md ? 1'b1 : rbit(), md ? rbit() : 1'b1,
                 OP_W'($urandom), FUNC_W'($urandom));
            if (sw) return;
        end
        push({name, ".WB"}, M_BUSY | M_RWE | (r ? M_RDST : '0) | (lw ? M_RWD : '0) | (imm ? M_ALUB : '0) | aluf,
             rbit(), rbit(), OP_W'($urandom), FUNC_W'($urandom));
    endtask

    task automatic run_sched(input int limit);
        cyc_t c;
        int n;
        n = 0;
        while ((sched.size() > 0) && (n < limit)) begin
            @(posedge clock);
            #1;
            c = sched.pop_front();
            opcode     = c.op;
            func       = c.fn;
            md_ready   = c.mdr;
            dmem_ready = c.dmr;
            check_val(c.tag, 32'(obs), 32'(c.exp));
            n++;
        end
    endtask

    // Called 1 ns after an edge: reset is raised mid-cycle, outputs must drop
    // with no clock edge, and release lands before the next edge.
    task automatic do_reset_mid(input string tag);
        #2 reset = 1'b1;
        #1 check_val(tag, 32'(obs), 32'd0);
        #3 reset = 1'b0;
        sched.delete();
        prev_ill = 1'b0;
    endtask

    task automatic run_instr(input string name, input logic [OP_W-1:0] op,
                             input logic [FUNC_W-1:0] fn, input int wt);
        bit h;
        gen_instr(name, op, fn, wt, h);
        run_sched(1000);
        if (h) do_reset_mid({name, ".halt_reset"});
    endtask

    initial begin
        bit h;
        logic [OP_W-1:0]   op;
        logic [FUNC_W-1:0] fn;
        int wt;
        int pick;
        n_tests    = 0;
        n_fail     = 0;
        prev_ill   = 1'b0;
        reset      = 1'b1;
        opcode     = '0;
        func       = '0;
        md_ready   = 1'b1;
        dmem_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1 check_val("reset_state", 32'(obs), 32'd0);
        #6 reset = 1'b0;

        run_instr("add",      5'd0,  5'd0, 0);
        run_instr("addi",     5'd5,  5'd9, 0);
        run_instr("lw3",      5'd8,  5'd3, 2);
        run_instr("sw0",      5'd7,  5'd1, 0);
        run_instr("div",      5'd0,  5'd7, 2);
        run_instr("ill31",    5'd31, 5'd0, 0);
        run_instr("mul_to",   5'd0,  5'd6, TO);
        run_instr("lw_edge",  5'd8,  5'd0, TO - 1);
        run_instr("sll",      5'd0,  5'd4, 0);
        run_instr("ill_fn",   5'd0,  5'd12, 0);
        run_instr("sw_to",    5'd7,  5'd2, TO);

        gen_instr("lw_mid", 5'd8, 5'd0, 8, h);
        run_sched(4);
        do_reset_mid("mid_mem_reset");
        run_instr("after_rst", 5'd0, 5'd1, 0);

        for (int i = 0; i < 80; i++) begin
            pick = $urandom_range(0, 9);
            fn   = FUNC_W'($urandom);
            case (pick)
                0, 1, 2: begin op = '0; fn = FUNC_W'($urandom_range(0, 7)); end
                3:       op = 5'd5;
                4:       op = 5'd7;
                5, 6:    op = 5'd8;
                7:       op = '0;
                default: op = OP_W'($urandom);
            endcase
            wt = ($urandom_range(0, 19) == 0) ? TO + $urandom_range(0, 3) : $urandom_range(0, 4);
            run_instr("rnd", op, fn, wt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
